// File: rtl/ps2_keystroke_decoder.sv
// PS/2 set-2 keyboard receiver: frames bytes, decodes make/break/extended prefixes into 5-bit key codes.
// Latency: outputs update one cycle after the stop bit's falling edge is seen (2-3 cycles pin-to-edge before that).
// Backpressure: none; strobes are single-cycle and the consumer must sample them when they occur.
module ps2_keystroke_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keystroke,
    output logic       keyPressed,
    output logic       keyReleased,
    output logic       frameError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          brk_q, ext_q;
    logic [4:0]    held_q;
    logic [4:0]    key_q;
    logic          key_prs_q, key_rel_q, frm_err_q;

    logic          fall_edge;
    logic          frame_ok;
    logic [4:0]    code;

    // Byte-to-key lookup: letters A..Z -> 1..26, then space, backspace, enter; anything else is 0.
    function automatic logic [4:0] map_code(input logic [7:0] b);
        logic [4:0] c;
        case (b)
            8'h1C: c = 5'd1;   8'h32: c = 5'd2;   8'h21: c = 5'd3;   8'h23: c = 5'd4;
            8'h24: c = 5'd5;   8'h2B: c = 5'd6;   8'h34: c = 5'd7;   8'h33: c = 5'd8;
            8'h43: c = 5'd9;   8'h3B: c = 5'd10;  8'h42: c = 5'd11;  8'h4B: c = 5'd12;
            8'h3A: c = 5'd13;  8'h31: c = 5'd14;  8'h44: c = 5'd15;  8'h4D: c = 5'd16;
            8'h15: c = 5'd17;  8'h2D: c = 5'd18;  8'h1B: c = 5'd19;  8'h2C: c = 5'd20;
            8'h3C: c = 5'd21;  8'h2A: c = 5'd22;  8'h1D: c = 5'd23;  8'h22: c = 5'd24;
            8'h35: c = 5'd25;  8'h1A: c = 5'd26;  8'h29: c = 5'd27;  8'h66: c = 5'd28;
            8'h5A: c = 5'd29;
            default: c = 5'd0;
        endcase
        return c;
    endfunction

    // Falling edge is the first synchronized-low cycle after a high one; data is sampled alongside it.
    assign fall_edge = clk_prev_q & ~clk_s2_q;
    // Odd parity over data+parity, and the stop bit currently being sampled must be high.
    assign frame_ok  = (^{shift_q, parity_q}) & dat_s2_q;
    assign code      = map_code(shift_q);

    assign keystroke   = key_q;
    assign keyPressed  = key_prs_q;
    assign keyReleased = key_rel_q;
    assign frameError  = frm_err_q;

    // Two-flop synchronizers plus edge-detect history; reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Frame FSM, inactivity timeout and byte decode with registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            held_q    <= '0;
            key_q     <= '0;
            key_prs_q <= 1'b0;
            key_rel_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            key_prs_q <= 1'b0;
            key_rel_q <= 1'b0;
            frm_err_q <= 1'b0;
            if (fall_edge) begin
                // An edge always wins over a coincident timeout.
                tmo_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (!frame_ok) begin
                            // A corrupted byte could have been a prefix, so forget any pending prefix.
                            frm_err_q <= 1'b1;
                            brk_q     <= 1'b0;
                            ext_q     <= 1'b0;
                        end else if (shift_q == 8'hF0) begin
                            brk_q <= 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else begin
                            brk_q <= 1'b0;
                            ext_q <= 1'b0;
                            // Extended keys are not part of the key set; unmapped bytes are ignored.
                            if (!ext_q && code != 5'd0) begin
                                if (brk_q) begin
                                    key_q     <= code;
                                    key_rel_q <= 1'b1;
                                    if (held_q == code) begin
                                        held_q <= '0;
                                    end
                                end else if (code != held_q) begin
                                    // A make equal to the held key is typematic auto-repeat.
                                    key_q     <= code;
                                    key_prs_q <= 1'b1;
                                    held_q    <= code;
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (tmo_q == TMO_MAX) begin
                    // Stalled mid-frame: drop the partial byte silently.
                    state_q <= ST_IDLE;
                    tmo_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keystroke_decoder.sv
// Scoreboarded bench for ps2_keystroke_decoder: directed scenarios then random byte streams.
// Expected events come from a byte-level keyboard model; a negedge monitor pops and compares.
// The decoder has no backpressure; every strobe must match the next queued expectation.
module tb_ps2_keystroke_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] keystroke;
    logic       keyPressed;
    logic       keyReleased;
    logic       frameError;

    int errors = 0;
    int checks = 0;

    ps2_keystroke_decoder #(.TIMEOUT_CYCLES(200)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keystroke  (keystroke),
        .keyPressed (keyPressed),
        .keyReleased(keyReleased),
        .frameError (frameError)
    );

    always #5 clk = ~clk;

    // kind: 0 press, 1 release, 2 frame error; code is the keystroke value expected alongside.
    typedef struct {
        int kind;
        int code;
    } exp_t;
    exp_t exp_q[$];

    // Keyboard-level model state.
    logic [7:0] key_tab[29] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                                8'h29, 8'h66, 8'h5A};
    int m_key  = 0;
    int m_held = 0;
    bit m_brk  = 0;
    bit m_ext  = 0;

    function automatic int code_of(input logic [7:0] b);
        for (int i = 0; i < 29; i++) begin
            if (key_tab[i] == b) return i + 1;
        end
        return 0;
    endfunction

    task automatic push_exp(input int kind, input int code);
        exp_t e;
        e.kind = kind;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        int c;
        if (bad) begin
            push_exp(2, m_key);
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            c = code_of(b);
            if (!m_ext && c != 0) begin
                if (m_brk) begin
                    m_key = c;
                    push_exp(1, c);
                    if (m_held == c) m_held = 0;
                end else if (c != m_held) begin
                    m_key  = c;
                    m_held = c;
                    push_exp(0, c);
                end
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic model_reset();
        m_key  = 0;
        m_held = 0;
        m_brk  = 0;
        m_ext  = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive the first n bits of an 11-bit frame (bit 0 = start), 40 clk cycles per PS/2 bit.
    task automatic send_raw(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cyc(10);
            ps2_clk = 1'b0;
            cyc(20);
            ps2_clk = 1'b1;
            cyc(10);
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] build_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad);
        model_byte(b, bad);
        send_raw(build_frame(b, bad), 11);
        cyc(60);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        chk({tag, "_keystroke"}, int'(keystroke), 0);
        chk({tag, "_keyPressed"}, int'(keyPressed), 0);
        chk({tag, "_keyReleased"}, int'(keyReleased), 0);
        chk({tag, "_frameError"}, int'(frameError), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard; keystroke must not move otherwise.
    logic [4:0] prev_ks = '0;
    logic       prev_rst = 1'b1;
    always @(negedge clk) begin
        int   nstrb;
        int   act_kind;
        exp_t e;
        if (!reset && !prev_rst) begin
            nstrb = int'(keyPressed) + int'(keyReleased) + int'(frameError);
            if (nstrb > 0) begin
                act_kind = keyPressed ? 0 : (keyReleased ? 1 : 2);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got kind %0d keystroke %0d, expected no strobe",
                             act_kind, keystroke);
                end else begin
                    e = exp_q.pop_front();
                    if (nstrb != 1 || act_kind != e.kind || int'(keystroke) != e.code) begin
                        errors++;
                        $display("FAIL strobe: got kind %0d keystroke %0d (%0d strobes), expected kind %0d keystroke %0d",
                                 act_kind, keystroke, nstrb, e.kind, e.code);
                    end
                end
            end else if (keystroke != prev_ks) begin
                checks++;
                errors++;
                $display("FAIL keystroke_stable: got %0d expected %0d (no strobe)", keystroke, prev_ks);
            end
        end
        prev_ks  = keystroke;
        prev_rst = reset;
    end

    initial begin
        logic [7:0] b;
        logic [7:0] last_b;
        int         r;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(3);
        reset = 1'b0;
        check_outputs_zero("reset");
        cyc(20);

        // Press and release.
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);

        // Typematic repeat, then a fresh press after release.
        send_frame(8'h2C, 0);
        send_frame(8'h2C, 0);
        send_frame(8'h2C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h2C, 0);
        send_frame(8'h2C, 0);

        // Parity error, then the good byte.
        send_frame(8'h29, 1);
        send_frame(8'h29, 0);

        // Extended and unmapped codes.
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        send_frame(8'h76, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h76, 0);
        send_frame(8'h5A, 0);

        // Timeout: start + 4 data bits, then idle long past the 200-cycle limit.
        send_raw(build_frame(8'hA5, 0), 5);
        cyc(300);
        send_frame(8'h66, 0);

        // Reset mid-frame clears held, so the same key presses again.
        send_frame(8'h1C, 0);
        send_raw(build_frame(8'h1C, 0), 6);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        model_reset();
        check_outputs_zero("midreset");
        cyc(20);
        send_frame(8'h1C, 0);

        // Random byte stream.
        last_b = 8'h1C;
        for (int n = 0; n < 50; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: b = key_tab[$urandom_range(0, 28)];
                5:             b = 8'hF0;
                6:             b = 8'hE0;
                7:             b = 8'($urandom_range(0, 255));
                default:       b = last_b;
            endcase
            last_b = b;
            send_frame(b, $urandom_range(0, 15) == 0);
            cyc($urandom_range(0, 60));
        end

        cyc(100);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_keystroke_decoder.md
# ps2_keystroke_decoder

Receives PS/2 (scan code set 2) frames from the keyboard and turns them into the 5-bit `keystroke` code and the one-cycle `keyReleased` strobe consumed by `PlayerActivity`. It is the producer end of the keystroke interface and sits between the board's PS/2 pins and the top level. It also flags framing errors.

## Interface
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `keystroke`  out  5  code of the most recently pressed or released key.
- `keyPressed`  out  1  one-cycle strobe: new key press, `keystroke` valid.
- `keyReleased`  out  1  one-cycle strobe: key released, `keystroke` holds the released key.
- `frameError`  out  1  one-cycle strobe: bad parity or bad stop bit.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A falling edge is the first cycle in which the synchronized clock is 0 after it was 1. Data is sampled on that cycle.
- **Frame FSM:** states IDLE, DATA, PARITY, STOP.
  - IDLE: an edge with data=0 (start bit) goes to DATA and clears the bit count. An edge with data=1 stays in IDLE.
  - DATA: 8 edges shift data in LSB first, then go to PARITY.
  - PARITY: one edge samples the parity bit, then goes to STOP.
  - STOP: one edge samples the stop bit, then returns to IDLE.
  - The frame is good if the 8 data bits plus the parity bit have odd parity and stop=1. Otherwise `frameError` pulses, the byte is dropped and the prefix flags are cleared.
- **Timeout:** a counter is cleared on every edge and counts in every non-IDLE state. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, the partial byte is dropped, and no strobe is produced.
- **Byte decode (good bytes only):**
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - Any other byte is a code byte, and `brk` and `ext` are cleared after it.
  - A code byte with `ext`=1 is discarded, including E0 F0 xx.
- **Code map, 0 meaning unmapped** (byte → code):
  - A..Z map to 1..26 from these make codes, in order: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Space 29 → 27. Backspace 66 → 28. Enter 5A → 29.
  - All other bytes → 0. Unmapped codes produce no strobe and leave `keystroke` unchanged.
- **Make (`brk`=0, mapped):**
  - If the code equals `held`, it is a typematic repeat and is ignored.
  - Otherwise `keystroke`←code, `keyPressed` pulses, and `held`←code.
- **Break (`brk`=1, mapped):**
  - `keystroke`←code and `keyReleased` pulses.
  - If the code equals `held`, `held`←0. Otherwise `held` is unchanged.
- **Reset:** all outputs 0, FSM to IDLE, shift register / bit count / timeout counter / `brk` / `ext` / `held` all 0, synchronizer flops to 1 (PS/2 bus idle level). Reset mid-frame discards the frame.

## Timing
- Let E be the cycle in which the stop bit's falling edge is detected. `keystroke`, `keyPressed`, `keyReleased` and `frameError` update at E+1.
- Strobes are high for exactly one cycle. At most one strobe is asserted per frame.
- `keystroke` holds its value between events and never glitches when no strobe is asserted.
- Pin-to-edge latency is 2–3 cycles (synchronizer plus edge detect).
- `reset` overrides any edge or timeout in the same cycle.
- The timeout fires on the cycle the counter equals `TIMEOUT_CYCLES`. An edge in that same cycle takes priority over the timeout: it is processed and the counter is cleared.
- Back-to-back frames with the minimum PS/2 spacing (about 50 µs) must be handled with no lost bytes.

## Test plan
- **Press and release:** frame 0x1C, then frames F0 and 1C → `keyPressed` for 1 cycle with `keystroke`=1, then `keyReleased` for 1 cycle with `keystroke`=1; `frameError` stays 0.
- **Typematic repeat:** 0x2C, 0x2C, 0x2C, then F0 2C → exactly one `keyPressed` (`keystroke`=20) and one `keyReleased`. A following 0x2C produces a new `keyPressed`.
- **Parity error:** frame 0x29 with an inverted parity bit → `frameError` pulses once, no key strobes, `keystroke` unchanged. The next good 0x29 gives `keystroke`=27 with `keyPressed`.
- **Extended and unmapped codes:** E0 75, E0 F0 75, 0x76 and F0 76 → no strobes, `keystroke` unchanged. A following 0x5A gives `keystroke`=29 with `keyPressed`.
- **Timeout:** with `TIMEOUT_CYCLES`=200, send a start bit plus 4 data bits, then hold both lines high for 300 cycles → no strobes. Then a full 0x66 frame → `keystroke`=28 with `keyPressed`.
- **Reset mid-frame:** press 0x1C (`held`=1), then assert `reset` for 1 cycle after 6 bits of the next frame → all outputs 0. Then a full 0x1C frame produces `keyPressed`, proving `held` was cleared.
